// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types, limits and BCD helpers for the microwave timer
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        BCD_MAX      = 4'd9;
    localparam bcd_t        SEC_TENS_MAX = 4'd5;
    localparam logic [15:0] TIME_MAX     = 16'h9959;

    // Increment a two-digit BCD minute field; bit 8 flags overflow past 99.
    function automatic logic [8:0] bcd_min_inc(input logic [7:0] m);
        if (m[3:0] != BCD_MAX)
            return {1'b0, m[7:4], m[3:0] + 4'd1};
        else if (m[7:4] != BCD_MAX)
            return {1'b0, m[7:4] + 4'd1, 4'd0};
        else
            return 9'h100;
    endfunction

    // Add 30 s to an MM:SS BCD time. Seconds tens 6-9 are first folded into
    // the minutes; any minute overflow saturates the result at 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [7:0] m;
        logic [3:0] s_t;
        logic [8:0] mi;
        logic       ovf;
        m   = t[15:8];
        s_t = t[7:4];
        mi  = 9'h000;
        ovf = 1'b0;
        if (s_t > SEC_TENS_MAX) begin
            s_t = s_t - 4'd6;
            mi  = bcd_min_inc(m);
            m   = mi[7:0];
            ovf = mi[8];
        end
        s_t = s_t + 4'd3;
        if (s_t > SEC_TENS_MAX) begin
            s_t = s_t - 4'd6;
            mi  = bcd_min_inc(m);
            m   = mi[7:0];
            ovf = ovf | mi[8];
        end
        return ovf ? TIME_MAX : {m, s_t, t[3:0]};
    endfunction

endpackage

// File: rtl/microwave_timer_prescaler.sv
// rtl/microwave_timer_prescaler.sv - enable-gated modulo-TICKS_PER_SEC counter with one-second pulse
module microwave_prescaler #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sec_pulse
);

    localparam int              CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt;

    assign sec_pulse = en && (cnt == LAST);

    // Count only while enabled, hold otherwise so a paused second resumes where it stopped.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - MM:SS BCD countdown timer; +30 s key enabled by MICROWAVE_ADD30_EN
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       mag_on,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       add30,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       running
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ARMED = ARMED;
    localparam logic [1:0] ST_RUN   = RUN;

    logic [1:0]  state, state_n;
    bcd_t        mt_n, mo_n, st_n, so_n;
    logic        sec_pulse;
    logic        count_zero_n;

`ifdef MICROWAVE_ADD30_EN
    logic [15:0] add30_sum;
    assign add30_sum = bcd_add30({min_tens, min_ones, sec_tens, sec_ones});
`else
    logic add30_unused;
    assign add30_unused = add30;
`endif

    microwave_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_RUN),
        .clr       (!clearn),
        .sec_pulse (sec_pulse)
    );

    // Next count and state: clear beats decrement, which beats +30 s, which beats keypad entry.
    always_comb begin
        mt_n    = min_tens;
        mo_n    = min_ones;
        st_n    = sec_tens;
        so_n    = sec_ones;
        state_n = state;
        if (!clearn) begin
            mt_n    = 4'd0;
            mo_n    = 4'd0;
            st_n    = 4'd0;
            so_n    = 4'd0;
        end else if (sec_pulse) begin
            if (sec_ones != 4'd0) begin
                so_n = sec_ones - 4'd1;
            end else if (sec_tens != 4'd0) begin
                so_n = BCD_MAX;
                st_n = sec_tens - 4'd1;
            end else if ((min_tens != 4'd0) || (min_ones != 4'd0)) begin
                so_n = BCD_MAX;
                st_n = SEC_TENS_MAX;
                if (min_ones != 4'd0) begin
                    mo_n = min_ones - 4'd1;
                end else begin
                    mo_n = BCD_MAX;
                    mt_n = min_tens - 4'd1;
                end
            end
        end
`ifdef MICROWAVE_ADD30_EN
        else if (add30) begin
            {mt_n, mo_n, st_n, so_n} = add30_sum;
        end
`endif
        else if ((state != ST_RUN) && digit_valid && (digit <= BCD_MAX)) begin
            mt_n = min_ones;
            mo_n = sec_tens;
            st_n = sec_ones;
            so_n = digit;
        end

        count_zero_n = ({mt_n, mo_n, st_n, so_n} == 16'h0000);

        if (!clearn) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (!count_zero_n) state_n = ST_ARMED;
                ST_ARMED: begin
                    if (count_zero_n)  state_n = ST_IDLE;
                    else if (mag_on)   state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (count_zero_n)  state_n = ST_IDLE;
                    else if (!mag_on)  state_n = ST_ARMED;
                end
                default:               state_n = ST_IDLE;
            endcase
        end
    end

    // Register count, state and the status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            state      <= ST_IDLE;
            timer_done <= 1'b1;
            running    <= 1'b0;
        end else begin
            min_tens   <= mt_n;
            min_ones   <= mo_n;
            sec_tens   <= st_n;
            sec_ones   <= so_n;
            state      <= state_n;
            timer_done <= count_zero_n;
            running    <= (state_n == ST_RUN);
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - directed self-checking bench for microwave_timer at TICKS_PER_SEC=4
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clearn;
    logic       mag_on;
    logic       digit_valid;
    logic [3:0] digit;
    logic       add30;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;
    logic       running;

    int n_vec  = 0;
    int n_miss = 0;

    microwave_timer #(
        .TICKS_PER_SEC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clearn      (clearn),
        .mag_on      (mag_on),
        .digit_valid (digit_valid),
        .digit       (digit),
        .add30       (add30),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .timer_done  (timer_done),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
    endtask

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        rst = 1'b1; clearn = 1'b1; mag_on = 1'b0;
        digit_valid = 1'b0; digit = 4'd0; add30 = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();
        check("reset_disp", disp(), 16'h0000);
        check("reset_done", timer_done, 1'b1);
        check("reset_run",  running, 1'b0);

        mag_on = 1'b1;
        tick();
        check("idle_magon_run", running, 1'b0);
        mag_on = 1'b0;

        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("shift_discard", disp(), 16'h2345);
        do_clear();
        check("clear_armed", disp(), 16'h0000);

        key(4'd1); key(4'd0); key(4'd5);
        check("load_0105", disp(), 16'h0105);
        check("load_done", timer_done, 1'b0);
        mag_on = 1'b1;
        tick();
        check("run_entry", running, 1'b1);
        check("run_entry_disp", disp(), 16'h0105);
        ticks(4);
        check("first_dec", disp(), 16'h0104);
        ticks(20);
        check("min_borrow", disp(), 16'h0059);
        ticks(235);
        check("done_early", timer_done, 1'b0);
        tick();
        check("done_260", timer_done, 1'b1);
        check("done_run", running, 1'b0);
        check("done_disp", disp(), 16'h0000);
        mag_on = 1'b0;

        key(4'd3);
        mag_on = 1'b1;
        tick();
        ticks(5);
        mag_on = 1'b0;
        tick();
        check("pause_run", running, 1'b0);
        check("pause_disp", disp(), 16'h0002);
        ticks(19);
        check("pause_hold", disp(), 16'h0002);
        check("pause_done", timer_done, 1'b0);
        mag_on = 1'b1;
        tick();
        check("resume_run", running, 1'b1);
        ticks(5);
        check("resume_early", timer_done, 1'b0);
        tick();
        check("resume_done", timer_done, 1'b1);
        mag_on = 1'b0;

        key(4'd4); key(4'd0);
        mag_on = 1'b1;
        tick();
        ticks(3);
        check("pre_clear", disp(), 16'h0040);
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
        check("clr_dec_disp", disp(), 16'h0000);
        check("clr_dec_done", timer_done, 1'b1);
        check("clr_dec_run", running, 1'b0);
        mag_on = 1'b0;
        tick();

        key(4'd2);
        mag_on = 1'b1;
        tick();
        key(4'd7);
        check("run_digit_ign", disp(), 16'h0002);
        check("run_digit_run", running, 1'b1);
        mag_on = 1'b0;
        do_clear();
        check("clr_run_disp", disp(), 16'h0000);

        key(4'd9);
        key(4'hA);
        check("bad_digit", disp(), 16'h0009);
        key(4'd9);
        check("load_0099", disp(), 16'h0099);
        mag_on = 1'b1;
        tick();
        ticks(395);
        check("s99_disp", disp(), 16'h0001);
        check("s99_early", timer_done, 1'b0);
        tick();
        check("s99_done", timer_done, 1'b1);
        mag_on = 1'b0;

`ifdef MICROWAVE_ADD30_EN
        add30 = 1'b1; tick(); add30 = 1'b0;
        check("add30_idle", disp(), 16'h0030);
        check("add30_done", timer_done, 1'b0);
        mag_on = 1'b1; tick();
        check("add30_armed", running, 1'b1);
        mag_on = 1'b0;
        do_clear();
        key(4'd4); key(4'd5);
        add30 = 1'b1; tick(); add30 = 1'b0;
        check("add30_carry", disp(), 16'h0115);
        do_clear();
        key(4'd9); key(4'd9); key(4'd5); key(4'd0);
        add30 = 1'b1; tick(); add30 = 1'b0;
        check("add30_sat", disp(), 16'h9959);
        do_clear();
        key(4'd9); key(4'd9);
        add30 = 1'b1; tick(); add30 = 1'b0;
        check("add30_norm", disp(), 16'h0209);
        do_clear();
`else
        add30 = 1'b1; tick(); add30 = 1'b0;
        check("add30_ignored", disp(), 16'h0000);
        check("add30_ign_done", timer_done, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
